// File: rtl/store_drain.sv
// Retires committed stores from the SAQ head into data memory via a req/ack write handshake.
// Optional feature: define STORE_DRAIN_FAULT_EN to report V=0 entries on o_fault instead of silently dropping them.
module store_drain #(
    parameter int WIDTH_TAG  = 5,
    parameter int WIDTH_ADDR = 32,
    parameter int WIDTH_WORD = 32,
    parameter int WIDTH      = 4,
    parameter int WIDTH_DATA = 4 + WIDTH_ADDR + WIDTH_TAG
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH_DATA-1:0] i_entry,
    input  logic                  i_empty,
    input  logic                  i_rob_val,
    input  logic [WIDTH_TAG-1:0]  i_rob_tag,
    input  logic                  i_weData,
    input  logic [WIDTH-1:0]      i_waddrData,
    input  logic [WIDTH_WORD-1:0] i_data,
    input  logic                  i_mem_ack,
    output logic                  o_re,
    output logic                  o_mem_req,
    output logic [WIDTH_ADDR-1:0] o_mem_addr,
    output logic [WIDTH_WORD-1:0] o_mem_data,
    output logic                  o_done,
    output logic [WIDTH_TAG-1:0]  o_done_tag,
    output logic                  o_fault,
    output logic                  o_busy
);

    localparam int SIZE     = 2 ** WIDTH;
    localparam int D_BIT    = WIDTH_TAG;
    localparam int V_BIT    = WIDTH_TAG + 1;
    localparam int ADDR_LSB = WIDTH_TAG + 2;
    localparam int VAL_BIT  = ADDR_LSB + WIDTH_ADDR;
    localparam int A_BIT    = VAL_BIT + 1;
    localparam logic [WIDTH-1:0] HEAD_STEP = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_POP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      head_q, head_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_TAG-1:0]  tag_q, tag_d;
    logic [WIDTH_WORD-1:0] rd_data_q;
    logic                  load_data;

    logic [WIDTH_WORD-1:0] data_mem [SIZE];

    logic                  e_a, e_val, e_v, e_d;
    logic [WIDTH_ADDR-1:0] e_addr;
    logic [WIDTH_TAG-1:0]  e_tag;
    logic                  eligible;

    assign e_a      = i_entry[A_BIT];
    assign e_val    = i_entry[VAL_BIT];
    assign e_addr   = i_entry[ADDR_LSB +: WIDTH_ADDR];
    assign e_v      = i_entry[V_BIT];
    assign e_d      = i_entry[D_BIT];
    assign e_tag    = i_entry[WIDTH_TAG-1:0];
    assign eligible = !i_empty && e_a && i_rob_val && (e_tag == i_rob_tag);

    // Store-data array: unreset, one write port, enabled registered read.
    always_ff @(posedge i_clk) begin
        if (i_weData) begin
            data_mem[i_waddrData] <= i_data;
        end
    end

    // Read-during-write to the head returns the old word; the D bit lands on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (load_data) begin
            rd_data_q <= data_mem[head_q];
        end
    end

`ifdef STORE_DRAIN_FAULT_EN
    logic fault_q, fault_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
`ifdef STORE_DRAIN_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
`ifdef STORE_DRAIN_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        load_data = 1'b0;
`ifdef STORE_DRAIN_FAULT_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    if (!e_val || !e_v) begin
                        // Killed or faulted: retire without touching memory.
                        state_d = ST_POP;
                        tag_d   = e_tag;
`ifdef STORE_DRAIN_FAULT_EN
                        fault_d = e_val;
`endif
                    end else if (e_d) begin
                        state_d   = ST_REQ;
                        addr_d    = e_addr;
                        tag_d     = e_tag;
                        load_data = 1'b1;
`ifdef STORE_DRAIN_FAULT_EN
                        fault_d   = 1'b0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                head_d  = head_q + HEAD_STEP;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_re       = (state_q == ST_POP);
    assign o_done     = (state_q == ST_POP);
    assign o_mem_req  = (state_q == ST_REQ);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_mem_addr = addr_q;
    assign o_mem_data = rd_data_q;
    assign o_done_tag = tag_q;

`ifdef STORE_DRAIN_FAULT_EN
    assign o_fault = (state_q == ST_POP) && fault_q;
`else
    assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain.sv
// Self-checking bench for store_drain: directed scenarios plus randomized SAQ heads against a behavioural model.
module tb_store_drain;
    localparam int WT   = 5;
    localparam int WA   = 32;
    localparam int WW   = 32;
    localparam int WI   = 4;
    localparam int WD   = 4 + WA + WT;
    localparam int SIZE = 16;

    localparam int K_NONE  = 0;
    localparam int K_KILL  = 1;
    localparam int K_FAULT = 2;
    localparam int K_STORE = 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [WD-1:0] i_entry;
    logic          i_empty;
    logic          i_rob_val;
    logic [WT-1:0] i_rob_tag;
    logic          i_weData;
    logic [WI-1:0] i_waddrData;
    logic [WW-1:0] i_data;
    logic          i_mem_ack;
    logic          o_re;
    logic          o_mem_req;
    logic [WA-1:0] o_mem_addr;
    logic [WW-1:0] o_mem_data;
    logic          o_done;
    logic [WT-1:0] o_done_tag;
    logic          o_fault;
    logic          o_busy;

    store_drain #(
        .WIDTH_TAG (WT),
        .WIDTH_ADDR(WA),
        .WIDTH_WORD(WW),
        .WIDTH     (WI),
        .WIDTH_DATA(WD)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_entry    (i_entry),
        .i_empty    (i_empty),
        .i_rob_val  (i_rob_val),
        .i_rob_tag  (i_rob_tag),
        .i_weData   (i_weData),
        .i_waddrData(i_waddrData),
        .i_data     (i_data),
        .i_mem_ack  (i_mem_ack),
        .o_re       (o_re),
        .o_mem_req  (o_mem_req),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_done     (o_done),
        .o_done_tag (o_done_tag),
        .o_fault    (o_fault),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int            checks = 0;
    int            errors = 0;
    logic [WW-1:0] mem_model [SIZE];
    int            exp_head = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic write_data(input int idx, input logic [WW-1:0] val);
        i_weData    = 1'b1;
        i_waddrData = WI'(idx);
        i_data      = val;
        @(negedge i_clk);
        i_weData    = 1'b0;
        mem_model[idx] = val;
    endtask

    // What the SAQ head should cause, taken straight from the drain rules.
    function automatic int classify(input logic a, input logic val, input logic v, input logic d,
                                    input logic [WT-1:0] tag, input logic [WT-1:0] rtag,
                                    input logic rval, input logic empty);
        if (empty || !a || !rval || tag != rtag) return K_NONE;
        if (!val) return K_KILL;
        if (!v) return K_FAULT;
        if (!d) return K_NONE;
        return K_STORE;
    endfunction

    task automatic run_store(input logic a, input logic val, input logic v, input logic d,
                             input logic [WT-1:0] tag, input logic [WA-1:0] addr,
                             input logic [WT-1:0] rtag, input logic rval, input logic empty,
                             input int delay, input logic wr_head, input logic [WW-1:0] wr_val);
        int            kind;
        logic [WW-1:0] exp_data;
        logic          exp_fault;
        kind     = classify(a, val, v, d, tag, rtag, rval, empty);
        exp_data = mem_model[exp_head];
`ifdef STORE_DRAIN_FAULT_EN
        exp_fault = (kind == K_FAULT);
`else
        exp_fault = 1'b0;
`endif
        i_entry   = {a, val, addr, v, d, tag};
        i_rob_tag = rtag;
        i_rob_val = rval;
        i_empty   = empty;
        if (wr_head) begin
            i_weData    = 1'b1;
            i_waddrData = WI'(exp_head);
            i_data      = wr_val;
            mem_model[exp_head] = wr_val;
        end
        if (kind == K_NONE) i_mem_ack = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        i_weData = 1'b0;
        if (kind == K_NONE) begin
            check("idle_req", 64'(o_mem_req), 64'(0));
            check("idle_re", 64'(o_re), 64'(0));
            check("idle_busy", 64'(o_busy), 64'(0));
            i_mem_ack = 1'b0;
            i_empty   = 1'b1;
            i_entry   = '0;
            return;
        end
        if (kind == K_STORE) begin
            check("req_rise", 64'(o_mem_req), 64'(1));
            check("req_busy", 64'(o_busy), 64'(1));
            check("req_addr", 64'(o_mem_addr), 64'(addr));
            check("req_data", 64'(o_mem_data), 64'(exp_data));
            check("req_no_re", 64'(o_re), 64'(0));
            for (int k = 0; k < delay; k++) begin
                // Disturb every input that must not matter while the request is outstanding.
                i_rob_tag = WT'($urandom);
                i_empty   = 1'($urandom_range(0, 1));
                i_entry   = WD'({$urandom, $urandom});
                write_data(int'($urandom_range(0, SIZE - 1)), $urandom);
                check("hold_req", 64'(o_mem_req), 64'(1));
                check("hold_addr", 64'(o_mem_addr), 64'(addr));
                check("hold_data", 64'(o_mem_data), 64'(exp_data));
                check("hold_no_re", 64'(o_re), 64'(0));
            end
            i_mem_ack = 1'b1;
            @(negedge i_clk);
            i_mem_ack = 1'b0;
        end
        check("pop_re", 64'(o_re), 64'(1));
        check("pop_done", 64'(o_done), 64'(1));
        check("pop_tag", 64'(o_done_tag), 64'(tag));
        check("pop_fault", 64'(o_fault), 64'(exp_fault));
        check("pop_no_req", 64'(o_mem_req), 64'(0));
        i_empty  = 1'b1;
        i_entry  = '0;
        exp_head = (exp_head + 1) % SIZE;
        @(negedge i_clk);
        check("back_idle", 64'(o_busy), 64'(0));
        check("back_no_re", 64'(o_re), 64'(0));
    endtask

    initial begin
        logic          ra, rval_b, rv, rd, rrv, remp, rwr;
        logic [WT-1:0] rtag, rrt;

        i_rst = 1'b1; i_entry = '0; i_empty = 1'b1; i_rob_val = 1'b0; i_rob_tag = '0;
        i_weData = 1'b0; i_waddrData = '0; i_data = '0; i_mem_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_re", 64'(o_re), 64'(0));
        check("rst_req", 64'(o_mem_req), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_fault", 64'(o_fault), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_addr", 64'(o_mem_addr), 64'(0));
        check("rst_data", 64'(o_mem_data), 64'(0));
        check("rst_tag", 64'(o_done_tag), 64'(0));
        i_rst = 1'b0;

        for (int i = 0; i < SIZE; i++) write_data(i, $urandom);
        write_data(0, 32'hDEADBEEF);

        // Basic store: ack in the second request cycle.
        run_store(1, 1, 1, 1, 5'd3, 32'h100, 5'd3, 1, 0, 1, 0, '0);
        // Tag mismatch stalls, then drains once the ROB head matches.
        run_store(1, 1, 1, 1, 5'd3, 32'h104, 5'd4, 1, 0, 0, 0, '0);
        run_store(1, 1, 1, 1, 5'd3, 32'h104, 5'd4, 1, 0, 0, 0, '0);
        run_store(1, 1, 1, 1, 5'd3, 32'h104, 5'd3, 1, 0, 2, 0, '0);
        // Killed entry, then faulted entry.
        run_store(1, 0, 1, 1, 5'd7, 32'h200, 5'd7, 1, 0, 0, 0, '0);
        run_store(1, 1, 0, 1, 5'd2, 32'h300, 5'd2, 1, 0, 0, 0, '0);
        // Data write to the head index in the check cycle: the old word is sent.
        run_store(1, 1, 1, 1, 5'd9, 32'h400, 5'd9, 1, 0, 0, 1, 32'hCAFEF00D);

        // Seventeen back-to-back stores force the head around the wrap.
        for (int i = 0; i < 17; i++) begin
            rtag = WT'($urandom);
            run_store(1, 1, 1, 1, rtag, $urandom, rtag, 1, 0, 0, 0, '0);
        end

        // Reset while a request is outstanding; the late ack must be ignored.
        i_entry   = {1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 5'd11};
        i_rob_tag = 5'd11; i_rob_val = 1'b1; i_empty = 1'b0;
        @(negedge i_clk);
        check("mid_req", 64'(o_mem_req), 64'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        check("mrst_req", 64'(o_mem_req), 64'(0));
        check("mrst_busy", 64'(o_busy), 64'(0));
        check("mrst_addr", 64'(o_mem_addr), 64'(0));
        check("mrst_tag", 64'(o_done_tag), 64'(0));
        i_rst = 1'b0; i_empty = 1'b1; i_entry = '0; i_mem_ack = 1'b1;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        check("late_ack_re", 64'(o_re), 64'(0));
        check("late_ack_busy", 64'(o_busy), 64'(0));
        exp_head = 0;
        run_store(1, 1, 1, 1, 5'd12, 32'h600, 5'd12, 1, 0, 0, 0, '0);

        // Randomized SAQ heads against the model.
        for (int i = 0; i < 60; i++) begin
            ra     = ($urandom_range(0, 9) != 0);
            rval_b = ($urandom_range(0, 5) != 0);
            rv     = ($urandom_range(0, 5) != 0);
            rd     = ($urandom_range(0, 4) != 0);
            rrv    = ($urandom_range(0, 7) != 0);
            remp   = ($urandom_range(0, 7) == 0);
            rwr    = ($urandom_range(0, 5) == 0);
            rtag   = WT'($urandom);
            rrt    = ($urandom_range(0, 4) != 0) ? rtag : WT'($urandom);
            write_data(int'($urandom_range(0, SIZE - 1)), $urandom);
            run_store(ra, rval_b, rv, rd, rtag, $urandom, rrt, rrv, remp,
                      int'($urandom_range(0, 3)), rwr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/store_drain.md
# store_drain

Drains committed stores from the head of the store address queue (SAQ) into data memory. It holds the store-data array, indexed like the SAQ, and mirrors the SAQ head pointer. A store drains only when the head entry is allocated, has its data available, and its tag matches the ROB head. The block then runs a req/ack write handshake toward the data cache and pulses the SAQ read-enable to retire the entry.

## Interface
- WIDTH_TAG, 5, ROB tag width
- WIDTH_ADDR, 32, store address width
- WIDTH_WORD, 32, store data width
- WIDTH, 4, SAQ index width; SIZE = 2**WIDTH entries
- WIDTH_DATA, 4+WIDTH_ADDR+WIDTH_TAG, SAQ entry width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_entry  in  WIDTH_DATA  SAQ head entry, packed MSB→LSB as {A, val, addr, V, D, tag}
- i_empty  in  1  SAQ empty
- i_rob_val  in  1  ROB head valid
- i_rob_tag  in  WIDTH_TAG  ROB head tag
- i_weData  in  1  store-data write strobe; same strobe as the SAQ D-bit write
- i_waddrData  in  WIDTH  store-data write index
- i_data  in  WIDTH_WORD  store data
- i_mem_ack  in  1  memory accepted the write
- o_re  out  1  SAQ pop, one-cycle pulse
- o_mem_req  out  1  memory write request
- o_mem_addr  out  WIDTH_ADDR  write address
- o_mem_data  out  WIDTH_WORD  write data
- o_done  out  1  store retired, one-cycle pulse
- o_done_tag  out  WIDTH_TAG  tag of the retired store
- o_fault  out  1  address-fault pulse (see Configuration)
- o_busy  out  1  FSM not in IDLE

## Operation
- Data array: SIZE×WIDTH_WORD.
  - Written at i_waddrData when i_weData is high.
  - Not reset.
- Head pointer `head`:
  - Reset value 0.
  - Increments on each o_re.
  - Wraps from SIZE-1 to 0.
  - Must track the SAQ head exactly.
- Eligible condition: !i_empty & A & i_rob_val & (tag == i_rob_tag).
- FSM states IDLE, REQ, POP.
- IDLE, when eligible:
  - val=0 (killed) → POP with no memory access.
  - val=1, V=0 (fault) → POP with no memory access; flag the fault.
  - val=1, V=1, D=1 → latch addr, data[head], and tag into output registers → REQ.
  - val=1, V=1, D=0 → stay in IDLE.
  - Otherwise stay in IDLE.
- REQ:
  - o_mem_req=1; o_mem_addr and o_mem_data held stable.
  - i_mem_ack=1 → POP.
  - Otherwise stay in REQ.
- POP:
  - o_re=1 and o_done=1, with o_done_tag = latched tag.
  - o_fault=1 if the fault flag is set.
  - head increments.
  - → IDLE.
- i_mem_ack outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE, head 0.
  - o_re, o_mem_req, o_done, o_fault, o_busy all 0.
  - o_mem_addr, o_mem_data, o_done_tag all 0.
- Normal store:
  - Eligible in cycle N.
  - o_mem_req rises in N+1.
  - Ack arrives in cycle M ≥ N+1.
  - o_re and o_done in M+1.
  - IDLE again in M+2.
  - Minimum 3 cycles per store.
- Killed or faulted entry: o_re in N+1; next eligibility check in N+2.
- o_mem_req stays asserted until ack. Address and data do not change while it is asserted.
- Data write to the head index in the same cycle as the IDLE check: the array read returns the old value. This is safe because the D bit is written at the same edge and is therefore still 0 in that cycle.
- i_empty rising while in REQ: no effect; the latched transaction completes.
- i_rob_tag changing after the REQ transition: no effect.
- i_rst mid-transaction: at the next edge o_mem_req drops to 0 and head returns to 0. The memory side must tolerate an abandoned request.

## Configuration
- STORE_DRAIN_FAULT_EN defined:
  - A V=0 entry pulses o_fault together with o_done in POP.
  - o_done_tag carries the faulting tag.
- STORE_DRAIN_FAULT_EN undefined:
  - V=0 entries are dropped exactly like killed entries.
  - o_fault is tied to 0.
  - The fault flag register is not built.

## Test plan
- Reset, then write data 0xDEADBEEF at index 0; SAQ head {A=1,val=1,addr=0x100,V=1,D=1,tag=3}; i_rob_tag=3, i_rob_val=1; ack after 2 cycles → o_mem_req for 2 cycles with addr 0x100 / data 0xDEADBEEF, then o_re=1 and o_done with tag 3 in the next cycle, head=1.
- Same entry but i_rob_tag=4 → stays in IDLE, no o_mem_req, no o_re; switch i_rob_tag to 3 → drains normally.
- Head entry val=0, tag=7, i_rob_tag=7 → o_re one cycle later, o_mem_req never asserted.
- Head entry V=0, tag=2 → with STORE_DRAIN_FAULT_EN: o_fault=1, o_done_tag=2 in the POP cycle; without the macro: o_fault=0.
- SIZE=16: drain 17 consecutive stores → head wraps 15→0→1, each store's data taken from the matching index.
- Assert i_rst in REQ → next cycle o_mem_req=0, o_busy=0, head=0; a late i_mem_ack is ignored.
